// File: rtl/rs485_uart_tx.sv
// Half-duplex RS485 8N1 transmitter with one-byte holding buffer and DE lead/tail guard times.
// Optional even parity bit between data and stop when RS485_TX_PARITY_EN is defined.
module rs485_uart_tx #(
  parameter int BIT_DIV   = 16,
  parameter int LEAD_BITS = 1,
  parameter int TAIL_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       tx_en,
  output logic       busy
);

  localparam logic [15:0] DIV_LAST  = 16'(BIT_DIV - 1);
  localparam logic [15:0] LEAD_LAST = 16'(LEAD_BITS - 1);
  localparam logic [15:0] TAIL_LAST = 16'(TAIL_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    START,
    DATA,
`ifdef RS485_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    TAIL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        din_ready_q, din_ready_d;
  logic        tx_q, tx_d;
  logic        tx_en_q, tx_en_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        load;
  logic        bit_end;
  logic        parity_q, parity_d;

`ifdef RS485_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  assign din_ready = din_ready_q;
  assign tx        = tx_q;
  assign tx_en     = tx_en_q;
  assign busy      = busy_q;

  // Next-state, divider, shifter, holding register and registered output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    parity_d    = parity_q;
    load        = 1'b0;
    accept      = din_valid && !hold_full_q;
    bit_end     = (div_q == DIV_LAST);

    if (state_q != IDLE) begin
      div_d = bit_end ? 16'd0 : div_q + 16'd1;
    end else begin
      div_d = 16'd0;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          cnt_d = 16'd0;
          if (LEAD_BITS != 0) begin
            state_d = LEAD;
          end else begin
            state_d = START;
            load    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LEAD: begin
        if (bit_end) begin
          if (cnt_q == LEAD_LAST) begin
            state_d = START;
            load    = 1'b1;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          state_d = LEAD;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = 16'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (cnt_q == 16'd7) begin
`ifdef RS485_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            cnt_d = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef RS485_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = 16'd0;
          if (hold_full_q) begin
            state_d = START;
            load    = 1'b1;
          end else if (TAIL_BITS != 0) begin
            state_d = TAIL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      TAIL: begin
        // A new byte cuts the tail short; the driver is already enabled so no re-lead.
        if (hold_full_q) begin
          state_d = START;
          load    = 1'b1;
          div_d   = 16'd0;
          cnt_d   = 16'd0;
        end else if (bit_end) begin
          if (cnt_q == TAIL_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          state_d = TAIL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
`ifdef RS485_TX_PARITY_EN
      parity_d    = even_parity(hold_q);
`else
      parity_d    = 1'b0;
`endif
    end else begin
      parity_d = parity_q;
    end

    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef RS485_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase

    tx_en_d     = (state_d != IDLE);
    busy_d      = (state_d != IDLE) || hold_full_d;
    din_ready_d = !hold_full_d;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= 16'd0;
      cnt_q       <= 16'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      din_ready_q <= 1'b1;
      tx_q        <= 1'b1;
      tx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      parity_q    <= parity_d;
      din_ready_q <= din_ready_d;
      tx_q        <= tx_d;
      tx_en_q     <= tx_en_d;
      busy_q      <= busy_d;
    end
  end

endmodule
